// File: rtl/mpc_qp_admm_fixpt.sv
// Fixed-point formats shared by every ADMM row engine: Q2.16 coefficients, Q16.16 x/y.
// Holds the rounding constant, saturation limits and the row FSM encoding.
package mpc_qp_admm_fixpt;

    localparam int CW        = 18;
    localparam int XW        = 32;
    localparam int COEF_FRAC = 16;
    localparam int X_FRAC    = 16;
    localparam int Y_FRAC    = 16;
    localparam int PW        = CW + XW;

    // Product carries COEF_FRAC+X_FRAC fraction bits; drop down to Y_FRAC with round-half-up.
    localparam int RES_SHIFT = COEF_FRAC + X_FRAC - Y_FRAC;
    localparam int ROUND_K   = 1 << (RES_SHIFT - 1);

    localparam logic [XW-1:0] Y_MAX = {1'b0, {(XW-1){1'b1}}};
    localparam logic [XW-1:0] Y_MIN = {1'b1, {(XW-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } row_state_e;

endpackage

// File: rtl/mpc_qp_admm_row_mac.sv
// Registered multiply (S2) then accumulate (S3); y_sat is the rounded, saturated view of acc.
// Latency: 2 cycles from vld_in to acc update; no backpressure, every valid term is consumed.
module mpc_qp_admm_row_mac
    import mpc_qp_admm_fixpt::*;
#(
    parameter int ACCW = 55
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              vld_in,
    input  logic [CW-1:0]     a,
    input  logic [XW-1:0]     b,
    output logic [ACCW-1:0]   acc_out,
    output logic [XW-1:0]     y_sat
);

    logic [PW-1:0]          r_p;
    logic                   r_p_vld;
    logic [ACCW-1:0]        r_acc;

    logic signed [PW-1:0]   w_a_ext;
    logic signed [PW-1:0]   w_b_ext;
    logic [ACCW-1:0]        w_rnd;
    logic signed [ACCW-1:0] w_shr;
    logic                   w_fit;

    assign w_a_ext = $signed({{(PW-CW){a[CW-1]}}, a});
    assign w_b_ext = $signed({{(PW-XW){b[XW-1]}}, b});

    // Operands are only captured under vld_in so idle (possibly X) ROM/RAM outputs never enter r_p.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p     <= '0;
            r_p_vld <= 1'b0;
            r_acc   <= '0;
        end else begin
            r_p_vld <= vld_in;
            if (vld_in) begin
                r_p <= w_a_ext * w_b_ext;
            end
            if (clr) begin
                r_acc <= '0;
            end else if (r_p_vld) begin
                r_acc <= r_acc + {{(ACCW-PW){r_p[PW-1]}}, r_p};
            end
        end
    end

    assign w_rnd = r_acc + ACCW'(ROUND_K);
    assign w_shr = $signed(w_rnd) >>> RES_SHIFT;
    assign w_fit = (&w_shr[ACCW-1:XW-1]) | ~(|w_shr[ACCW-1:XW-1]);

    always_comb begin
        y_sat = w_shr[XW-1:0];
        if (!w_fit) begin
            y_sat = w_shr[ACCW-1] ? Y_MIN : Y_MAX;
        end
    end

    assign acc_out = r_acc;

endmodule

// File: rtl/mpc_qp_admm_row_dot.sv
// One Hessian-row dot product y = sum H[r][k]*x[k], streamed from a 1-cycle ROM and x RAM.
// Latency: ap_done N+4 cycles after ap_start; back-to-back every N+5; ap_start outside IDLE/DONE is dropped.
module mpc_qp_admm_row_dot
    import mpc_qp_admm_fixpt::*;
#(
    parameter int N    = 24,
    parameter int AW   = 5,
    parameter int ACCW = CW + XW + $clog2(N)
) (
    input  logic            ap_clk,
    input  logic            ap_rst_n,
    input  logic            ap_start,
    output logic            ap_idle,
    output logic            ap_done,
    output logic            ap_ready,
    output logic [AW-1:0]   h_address0,
    output logic            h_ce0,
    input  logic [CW-1:0]   h_q0,
    output logic [AW-1:0]   x_address0,
    output logic            x_ce0,
    input  logic [XW-1:0]   x_q0,
    output logic [XW-1:0]   y
);

    localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

    row_state_e         r_state;
    row_state_e         w_next;
    logic [AW-1:0]      r_idx;
    logic [2:0]         r_vld;
    logic [XW-1:0]      r_y;

    logic               w_issue;
    logic               w_clr;
    logic               w_load_y;
    logic [XW-1:0]      w_y_sat;
    logic [ACCW-1:0]    w_acc_unused;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:  if (ap_start) w_next = ST_RUN;
            ST_RUN:   if (r_idx == LAST_IDX) w_next = ST_DRAIN;
            ST_DRAIN: if (r_vld == 3'b000) w_next = ST_DONE;
            ST_DONE:  w_next = ap_start ? ST_RUN : ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    assign w_issue  = (r_state == ST_RUN);
    assign w_clr    = (w_next == ST_RUN) && (r_state != ST_RUN);
    assign w_load_y = (r_state == ST_DRAIN) && (w_next == ST_DONE);

    // r_vld mirrors the term travelling through S1 (q valid), S2 (product) and S3 (acc update).
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_vld   <= '0;
            r_y     <= '0;
        end else begin
            r_state <= w_next;
            r_vld   <= {r_vld[1:0], w_issue};
            if (w_issue && (r_idx != LAST_IDX)) begin
                r_idx <= r_idx + AW'(1);
            end else begin
                r_idx <= '0;
            end
            if (w_load_y) begin
                r_y <= w_y_sat;
            end
        end
    end

    mpc_qp_admm_row_mac #(
        .ACCW (ACCW)
    ) u_mac (
        .clk     (ap_clk),
        .rst_n   (ap_rst_n),
        .clr     (w_clr),
        .vld_in  (r_vld[0]),
        .a       (h_q0),
        .b       (x_q0),
        .acc_out (w_acc_unused),
        .y_sat   (w_y_sat)
    );

    assign h_address0 = r_idx;
    assign x_address0 = r_idx;
    assign h_ce0      = w_issue;
    assign x_ce0      = w_issue;
    assign ap_idle    = (r_state == ST_IDLE);
    assign ap_done    = (r_state == ST_DONE);
    assign ap_ready   = ap_done;
    assign y          = r_y;

endmodule

// File: tb/tb_mpc_qp_admm_row_dot.sv
// Directed bench for the row dot-product engine: values, protocol timing, rounding, saturation, reset abort.
module tb_mpc_qp_admm_row_dot;

    logic        ap_clk;
    logic        ap_rst_n;
    logic        ap_start;
    logic        ap_idle;
    logic        ap_done;
    logic        ap_ready;
    logic [4:0]  h_address0;
    logic        h_ce0;
    logic [17:0] h_q0;
    logic [4:0]  x_address0;
    logic        x_ce0;
    logic [31:0] x_q0;
    logic [31:0] y;

    logic [17:0] h_mem [0:31];
    logic [31:0] x_mem [0:31];

    int n_chk;
    int n_err;

    mpc_qp_admm_row_dot dut (
        .ap_clk     (ap_clk),
        .ap_rst_n   (ap_rst_n),
        .ap_start   (ap_start),
        .ap_idle    (ap_idle),
        .ap_done    (ap_done),
        .ap_ready   (ap_ready),
        .h_address0 (h_address0),
        .h_ce0      (h_ce0),
        .h_q0       (h_q0),
        .x_address0 (x_address0),
        .x_ce0      (x_ce0),
        .x_q0       (x_q0),
        .y          (y)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    // 1-cycle registered ROM / RAM; outputs go unknown when not enabled.
    always @(posedge ap_clk) begin
        h_q0 <= h_ce0 ? h_mem[h_address0] : 'x;
        x_q0 <= x_ce0 ? x_mem[x_address0] : 'x;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [17:0] hv, input logic [31:0] xv);
        for (int i = 0; i < 32; i++) begin
            h_mem[i] = hv;
            x_mem[i] = xv;
        end
    endtask

    // Returns at the falling edge right after the rising edge that sampled ap_start (cycle 0).
    task automatic start_pulse();
        @(negedge ap_clk);
        ap_start = 1'b1;
        @(negedge ap_clk);
        ap_start = 1'b0;
    endtask

    task automatic wait_done(input int c0, input int exp_cyc, input logic [31:0] exp_y, input string tag);
        int c;
        c = c0;
        while (!ap_done && c < 80) begin
            @(negedge ap_clk);
            c++;
        end
        chk({tag, "_latency"}, 64'(c), 64'(exp_cyc));
        chk({tag, "_y"}, 64'(y), 64'(exp_y));
    endtask

    initial begin
        int nd;
        int d;
        n_chk    = 0;
        n_err    = 0;
        ap_start = 1'b0;
        ap_rst_n = 1'b0;
        fill(18'h0, 32'h0);

        repeat (3) @(negedge ap_clk);
        chk("rst_idle",  64'(ap_idle), 64'd1);
        chk("rst_done",  64'(ap_done), 64'd0);
        chk("rst_ready", 64'(ap_ready), 64'd0);
        chk("rst_hce",   64'(h_ce0), 64'd0);
        chk("rst_xce",   64'(x_ce0), 64'd0);
        chk("rst_haddr", 64'(h_address0), 64'd0);
        chk("rst_xaddr", 64'(x_address0), 64'd0);
        chk("rst_y",     64'(y), 64'd0);
        ap_rst_n = 1'b1;
        repeat (2) @(negedge ap_clk);

        // Unit vector e16 against row with +1.0 at 16 and -1.0 at 20; cycle-by-cycle protocol.
        h_mem[16] = 18'h10000;
        h_mem[20] = 18'h30000;
        x_mem[16] = 32'h0001_0000;
        start_pulse();
        for (int c = 0; c < 30; c++) begin
            if (c > 0) @(negedge ap_clk);
            chk($sformatf("proto_hce_c%0d", c), 64'(h_ce0), 64'(c <= 23));
            chk($sformatf("proto_xce_c%0d", c), 64'(x_ce0), 64'(c <= 23));
            if (c <= 23) begin
                chk($sformatf("proto_haddr_c%0d", c), 64'(h_address0), 64'(c));
                chk($sformatf("proto_xaddr_c%0d", c), 64'(x_address0), 64'(c));
            end
            chk($sformatf("proto_done_c%0d", c), 64'(ap_done), 64'(c == 28));
            chk($sformatf("proto_ready_c%0d", c), 64'(ap_ready), 64'(c == 28));
            chk($sformatf("proto_idle_c%0d", c), 64'(ap_idle), 64'(c == 29));
            if (c == 28) chk("e16_y", 64'(y), 64'h0001_0000);
        end
        chk("e16_y_held", 64'(y), 64'h0001_0000);

        // e20 hits the -1.0 coefficient.
        fill(18'h0, 32'h0);
        h_mem[16] = 18'h10000;
        h_mem[20] = 18'h30000;
        x_mem[20] = 32'h0001_0000;
        start_pulse();
        wait_done(0, 28, 32'hFFFF_0000, "e20");

        // Positive and negative saturation.
        fill(18'h1FFFF, 32'h7FFF_FFFF);
        start_pulse();
        wait_done(0, 28, 32'h7FFF_FFFF, "sat_pos");
        fill(18'h1FFFF, 32'h8000_0000);
        start_pulse();
        wait_done(0, 28, 32'h8000_0000, "sat_neg");

        // Round half up at the lsb of the result.
        fill(18'h0, 32'h0);
        h_mem[0] = 18'h00001;
        x_mem[0] = 32'h0000_8000;
        start_pulse();
        wait_done(0, 28, 32'h0000_0001, "rnd_half");
        x_mem[0] = 32'h0000_7FFF;
        start_pulse();
        wait_done(0, 28, 32'h0000_0000, "rnd_below");

        // Back-to-back with ap_start held: 1*1.0 + (-1)*2.0 = -1.0 each time.
        fill(18'h0, 32'h0);
        h_mem[16] = 18'h10000;
        h_mem[20] = 18'h30000;
        x_mem[16] = 32'h0001_0000;
        x_mem[20] = 32'h0002_0000;
        @(negedge ap_clk);
        ap_start = 1'b1;
        @(negedge ap_clk);
        wait_done(0, 28, 32'hFFFF_0000, "b2b_first");
        d = 0;
        do begin
            @(negedge ap_clk);
            d++;
        end while (!ap_done && d < 80);
        ap_start = 1'b0;
        chk("b2b_period", 64'(d), 64'd29);
        chk("b2b_second_y", 64'(y), 64'hFFFF_0000);
        @(negedge ap_clk);
        chk("b2b_done_width", 64'(ap_done), 64'd0);

        // A start pulse during RUN must neither shift timing nor queue a second op.
        start_pulse();
        repeat (10) @(negedge ap_clk);
        ap_start = 1'b1;
        @(negedge ap_clk);
        ap_start = 1'b0;
        wait_done(11, 28, 32'hFFFF_0000, "midrun");
        nd = 0;
        repeat (40) begin
            @(negedge ap_clk);
            if (ap_done) nd++;
        end
        chk("midrun_no_extra_done", 64'(nd), 64'd0);
        chk("midrun_idle", 64'(ap_idle), 64'd1);

        // Reset at cycle 10 of an op: outputs clear at once and the op never completes.
        fill(18'h0, 32'h0);
        h_mem[16] = 18'h10000;
        h_mem[20] = 18'h30000;
        x_mem[16] = 32'h0001_0000;
        start_pulse();
        repeat (10) @(negedge ap_clk);
        ap_rst_n = 1'b0;
        #1;
        chk("abort_y",   64'(y), 64'd0);
        chk("abort_hce", 64'(h_ce0), 64'd0);
        chk("abort_xce", 64'(x_ce0), 64'd0);
        chk("abort_idle", 64'(ap_idle), 64'd1);
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        nd = 0;
        repeat (40) begin
            @(negedge ap_clk);
            if (ap_done) nd++;
        end
        chk("abort_no_done", 64'(nd), 64'd0);
        start_pulse();
        wait_done(0, 28, 32'h0001_0000, "post_abort");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
